// File: rtl/senone_rom_sequencer_pkg.sv
// Shared types for the senone scoring path: fixed-point sample type, ROM record
// layout and the ROM sequencer state encoding.
package p3p_types;
  localparam int N_SENONES    = 12;
  localparam int N_COMPONENTS = 6;

  typedef logic signed [15:0] num;

  typedef struct packed {
    num                    k;
    num [N_COMPONENTS-1:0] omegas;
    num [N_COMPONENTS-1:0] means;
  } senone_data;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEEK,
    S_LOAD,
    S_STREAM,
    S_DONE
  } seq_state_t;
endpackage

// File: rtl/senone_rom_sequencer.sv
// Walks the senone ROM for one frame: skips masked-off senones, latches each
// enabled record and streams its Gaussian components one beat at a time.
module senone_rom_sequencer
  import p3p_types::*;
#(
  parameter int N_COMPONENTS = p3p_types::N_COMPONENTS,
  parameter int N_SENONES    = p3p_types::N_SENONES,
  parameter int IDX_W        = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N_SENONES-1:0] active_mask,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     rom_index,
  input  senone_data           rom_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_senone,
  output num                   out_k,
  output num                   out_omega,
  output num                   out_mean,
  output logic                 out_first,
  output logic                 out_last
);
  localparam int COMP_W = (N_COMPONENTS > 1) ? $clog2(N_COMPONENTS) : 1;
  localparam logic [COMP_W-1:0] LAST_COMP = COMP_W'(N_COMPONENTS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_SENONES - 1);

  seq_state_t           state, state_n;
  logic [N_SENONES-1:0] mask, mask_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [COMP_W-1:0]    comp, comp_n;
  senone_data           rec, rec_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      mask  <= '0;
      idx   <= '0;
      comp  <= '0;
      rec   <= '0;
    end else begin
      state <= state_n;
      mask  <= mask_n;
      idx   <= idx_n;
      comp  <= comp_n;
      rec   <= rec_n;
    end
  end

  always_comb begin
    state_n = state;
    mask_n  = mask;
    idx_n   = idx;
    comp_n  = comp;
    rec_n   = rec;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          mask_n  = active_mask;
          idx_n   = '0;
          state_n = S_SEEK;
        end
      end
      S_SEEK: begin
        if (mask[idx])            state_n = S_LOAD;
        else if (idx == LAST_IDX) state_n = S_DONE;
        else                      idx_n   = idx + 1'b1;
      end
      S_LOAD: begin
        // rom_index has been idx since SEEK picked it, so rom_data is settled.
        rec_n   = rom_data;
        comp_n  = '0;
        state_n = S_STREAM;
      end
      S_STREAM: begin
        if (out_ready) begin
          if (comp == LAST_COMP) begin
            if (idx == LAST_IDX) begin
              state_n = S_DONE;
            end else begin
              idx_n   = idx + 1'b1;
              state_n = S_SEEK;
            end
          end else begin
            comp_n = comp + 1'b1;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Beat fields are pure functions of held registers, so they stay put under backpressure.
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign out_valid  = (state == S_STREAM);
  assign rom_index  = idx;
  assign out_senone = idx;
  assign out_k      = rec.k;
  assign out_omega  = rec.omegas[comp];
  assign out_mean   = rec.means[comp];
  assign out_first  = out_valid && (comp == '0);
  assign out_last   = out_valid && (comp == LAST_COMP);
endmodule

// File: tb/tb_senone_rom_sequencer.sv
// Randomized bench for senone_rom_sequencer with a ROM model and a queue-based
// expected-beat model derived from the frame mask.
module tb_senone_rom_sequencer;
  import p3p_types::*;
  localparam int IDX_W = 5;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic                 out_ready = 1'b0;
  logic [N_SENONES-1:0] active_mask = '0;
  logic                 busy, done, out_valid, out_first, out_last;
  logic [IDX_W-1:0]     rom_index, out_senone;
  num                   out_k, out_omega, out_mean;
  senone_data           rom_data;

  num rk [N_SENONES];
  num rom_om [N_SENONES][N_COMPONENTS];
  num rom_mn [N_SENONES][N_COMPONENTS];

  always_comb begin
    rom_data = '0;
    if (int'(rom_index) < N_SENONES) begin
      rom_data.k = rk[rom_index];
      for (int c = 0; c < N_COMPONENTS; c++) begin
        rom_data.omegas[c] = rom_om[rom_index][c];
        rom_data.means[c]  = rom_mn[rom_index][c];
      end
    end
  end

  senone_rom_sequencer #(.N_COMPONENTS(N_COMPONENTS), .N_SENONES(N_SENONES), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .start(start), .active_mask(active_mask),
    .busy(busy), .done(done), .rom_index(rom_index), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_senone(out_senone),
    .out_k(out_k), .out_omega(out_omega), .out_mean(out_mean),
    .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sen;
    int comp;
    num k;
    num om;
    num mn;
  } beat_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  int tests = 0;
  int fails = 0;
  int done_cnt;

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%04h exp=%04h at %0t", nm, got, exp, $time);
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: hold ready low 3 cycles on comp 2
  task automatic run_pass(input logic [N_SENONES-1:0] m, input int mode,
                          input bit busy_start, input bit rst_mid);
    int    cyc, n_act, first_j, nvalid, last_xfer, last_sen, stalls;
    bit    seen_done, seen_valid, prev_stall, finished;
    beat_t b;
    exp_q.delete();
    got_q.delete();
    n_act = 0; first_j = -1; last_sen = -1;
    for (int i = 0; i < N_SENONES; i++) begin
      if (m[i]) begin
        n_act++;
        if (first_j < 0) first_j = i;
        last_sen = i;
        for (int c = 0; c < N_COMPONENTS; c++) begin
          b.sen = i; b.comp = c; b.k = rk[i]; b.om = rom_om[i][c]; b.mn = rom_mn[i][c];
          exp_q.push_back(b);
        end
      end
    end
    done_cnt = 0;
    @(negedge clk);
    active_mask = m;
    start = 1'b1;
    out_ready = 1'b1;
    cyc = 0; nvalid = 0; last_xfer = -1; stalls = 0;
    seen_done = 0; seen_valid = 0; prev_stall = 0; finished = 0;
    while (!finished) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc > 600) begin
        chk("timeout", cyc, 600);
        finished = 1;
      end else if (seen_done) begin
        chk("busy_after_done", int'(busy), 0);
        chk("single_done", int'(done), 0);
        chk("done_count", done_cnt, 1);
        finished = 1;
      end else if (rst_mid && out_valid && exp_q.size() > 0 && exp_q[0].comp == 3) begin
        reset = 1'b1;
        @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_index", int'(rom_index), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("rst_no_done", int'(done), 0);
          chk("rst_idle", int'(busy), 0);
        end
        finished = 1;
      end else begin
        chk("busy", int'(busy), 1);
        if (prev_stall) chk("stall_hold_valid", int'(out_valid), 1);
        if (out_valid) begin
          nvalid++;
          if (!seen_valid) begin
            seen_valid = 1;
            chk("first_beat_latency", cyc, first_j + 3);
          end
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            b = exp_q[0];
            chk("senone", int'(out_senone), b.sen);
            chk16("k", out_k, b.k);
            chk16("omega", out_omega, b.om);
            chk16("mean", out_mean, b.mn);
            chk("first", int'(out_first), int'(b.comp == 0));
            chk("last", int'(out_last), int'(b.comp == N_COMPONENTS - 1));
          end
        end
        if (done) begin
          done_cnt++;
          seen_done = 1;
          chk("done_queue_empty", exp_q.size(), 0);
          chk("done_cycle", cyc, N_SENONES + n_act + nvalid + 1);
          if (n_act > 0) chk("done_after_last", cyc - last_xfer, 1 + (N_SENONES - 1 - last_sen));
        end
        case (mode)
          0: out_ready = 1'b1;
          1: out_ready = ($urandom_range(0, 3) != 0);
          default: begin
            if (out_valid && exp_q.size() > 0 && exp_q[0].comp == 2 && stalls < 3) begin
              out_ready = 1'b0;
              stalls++;
              chk16("bp_omega", out_omega, 16'h0011);
              chk16("bp_mean", out_mean, 16'hFADD);
            end else begin
              out_ready = 1'b1;
            end
          end
        endcase
        prev_stall = out_valid && !out_ready;
        if (out_valid && out_ready && exp_q.size() > 0) begin
          b.sen = int'(out_senone); b.comp = exp_q[0].comp;
          b.k = out_k; b.om = out_omega; b.mn = out_mean;
          got_q.push_back(b);
          void'(exp_q.pop_front());
          last_xfer = cyc;
        end
        if (busy_start && cyc == 5) begin
          start = 1'b1;
          active_mask = '1;
        end
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic s1_literals();
    chk("s1_beats", got_q.size(), N_COMPONENTS);
    if (got_q.size() == N_COMPONENTS) begin
      chk("s1_sen0", got_q[0].sen, 0);
      chk16("s1_k", got_q[0].k, 16'hD075);
      chk16("s1_om0", got_q[0].om, 16'h002B);
      chk16("s1_mn0", got_q[0].mn, 16'h17A3);
      chk16("s1_om5", got_q[5].om, 16'h000C);
      chk16("s1_mn5", got_q[5].mn, 16'hEBCB);
    end
  endtask

  initial begin
    for (int i = 0; i < N_SENONES; i++) begin
      rk[i] = num'($urandom_range(0, 65535));
      for (int c = 0; c < N_COMPONENTS; c++) begin
        rom_om[i][c] = num'($urandom_range(0, 65535));
        rom_mn[i][c] = num'($urandom_range(0, 65535));
      end
    end
    rk[0] = 16'hD075;
    rom_om[0][0] = 16'h002B; rom_mn[0][0] = 16'h17A3;
    rom_om[0][2] = 16'h0011; rom_mn[0][2] = 16'hFADD;
    rom_om[0][5] = 16'h000C; rom_mn[0][5] = 16'hEBCB;
    rk[11] = 16'hD5F7;
    rom_om[11][0] = 16'h002E; rom_mn[11][0] = 16'h2640;
    rom_om[11][5] = 16'h0013; rom_mn[11][5] = 16'hE0F4;

    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_index", int'(rom_index), 0);
    chk16("reset_omega", out_omega, 16'h0000);
    chk16("reset_k", out_k, 16'h0000);
    reset = 1'b0;
    @(negedge clk);

    run_pass(12'h001, 0, 0, 0);
    s1_literals();

    run_pass(12'h000, 0, 0, 0);
    chk("empty_no_beats", got_q.size(), 0);

    run_pass(12'h801, 0, 0, 0);
    chk("s801_beats", got_q.size(), 2 * N_COMPONENTS);
    if (got_q.size() == 2 * N_COMPONENTS) begin
      chk("s801_sen", got_q[6].sen, 11);
      chk16("s801_k", got_q[6].k, 16'hD5F7);
      chk16("s801_om0", got_q[6].om, 16'h002E);
      chk16("s801_mn0", got_q[6].mn, 16'h2640);
      chk16("s801_om5", got_q[11].om, 16'h0013);
      chk16("s801_mn5", got_q[11].mn, 16'hE0F4);
    end

    run_pass(12'h001, 2, 0, 0);
    chk("bp_beats", got_q.size(), N_COMPONENTS);
    for (int i = 0; i < got_q.size(); i++) chk("bp_order", got_q[i].comp, i);

    run_pass(12'h001, 0, 1, 0);
    chk("busy_start_beats", got_q.size(), N_COMPONENTS);

    run_pass(12'h001, 0, 0, 1);
    run_pass(12'h001, 0, 0, 0);
    s1_literals();

    for (int r = 0; r < 15; r++) begin
      run_pass(N_SENONES'($urandom_range(0, 4095)), 1, ($urandom_range(0, 1) == 1), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
